port_sink: RTL and testbench
============================

Name: port_sink

Overview:
- Consumer endpoint for the node write/read port handshake; terminates an edge port of a node row (e.g. writeD/out/wreadyD of the bottom row) as the reader side.
- Accepts values a node writes and buffers them in a FIFO.
- Drains them to a host-side valid/ready stream.
- Counts accepted values against a programmable target so a test harness can tell when the expected output has been produced.

Parameters:
- WIDTH, 11, data width; two's-complement node value.
- DEPTH, 8, FIFO entries; power of two, minimum 2.
- CNT_W, 8, width of the target and count fields.

Ports:
- clk  input  1  clock; all state changes on rising edge.
- rst  input  1  reset, asynchronous, active-low.
- start  input  1  single-cycle pulse; latches target and enters RUN.
- target  input  CNT_W  number of values to accept; 0 = unlimited.
- write  input  1  node write request; driven from the node's write output.
- data  input  WIDTH  node output value; valid while write=1.
- read  output  1  reader ready; drives the node's wready input.
- m_valid  output  1  host stream valid.
- m_data  output  WIDTH  host stream data, FIFO head.
- m_ready  input  1  host accepts m_data.
- count  output  CNT_W  values accepted since last start.
- level  output  $clog2(DEPTH+1)  current FIFO occupancy.
- busy  output  1  state == RUN.
- done  output  1  state == DONE.

Behaviour:
- Reset (rst=0, asynchronous):
  - state=IDLE, FIFO empty (level=0), count=0.
  - latched target=0.
  - read=0, m_valid=0, m_data=0, busy=0, done=0.
- States and transitions:
  - IDLE: read=0. start -> RUN.
  - RUN: read=1 iff FIFO not full.
  - RUN -> DONE: on the edge of a transfer that makes count equal a nonzero latched target.
  - DONE: read=0; stays until the next start.
  - start in any state (including RUN or DONE): count<=0, target latched, state<=RUN. FIFO contents are kept.
- read:
  - Combinational from registered state only: read = (state==RUN) && (level!=DEPTH).
  - No dependence on write, so there is no combinational loop with the node.
- Transfer:
  - Occurs at a rising edge where write=1 and read=1.
  - data is pushed at the tail; count increments by 1.
  - In unlimited mode, count wraps modulo 2^CNT_W.
  - write=1 with read=0 is a stall: no push and no state change. The node holds write and data.
- start coinciding with a transfer: the transfer is discarded. count=0 after the edge and nothing is pushed.
- Host side:
  - m_valid = (level!=0); m_data = FIFO head (0 when empty).
  - A pop occurs on an edge with m_valid && m_ready.
  - Pop on empty is ignored.
- Latency: a value pushed at edge N is visible on m_data/m_valid after edge N (first-word fall-through from registers). One cycle from write acceptance to host visibility.
- Simultaneous push and pop:
  - Allowed when not full; level is unchanged; head and tail both advance.
  - When full, read=0, so a same-cycle pop does not enable a push. The push happens on the next cycle.
- Full/empty:
  - Pointers are log2(DEPTH)+1 bits with wrap bit.
  - full when the low bits are equal and the wrap bits differ.
  - level = tail - head.
- Data width: values are stored bit-exact; no sign interpretation or saturation.
- Host draining in IDLE/DONE is permitted; the FIFO continues to empty.

Test Plan:
- Reset, then start with target=3; node writes 5, -7 (0x7F9), 999 back-to-back with m_ready=1. Required: read=1 for each transfer; m_data sequence 5, 0x7F9, 999 one cycle after each; count=3; done=1 and read=0 after the third edge.
- target=0, m_ready=0, 10 writes with DEPTH=8. Required: 8 accepted, read=0 with level=8 and write stalled. Raise m_ready for 1 cycle: head popped and read=1 next cycle; ninth value accepted the following edge. Final order preserved.
- Full FIFO with m_ready=1 and write=1 every cycle. Required: steady state alternates pop/push per the full rule; no loss or duplication over 32 values (checked against a scoreboard).
- start pulsed in RUN with count=2 and level=2. Required: count=0, FIFO still holds both values, state RUN. A start coincident with write=1 does not push.
- Assert rst low mid-stream with level=5 and write=1. Required: immediately read=0, m_valid=0, level=0, count=0, busy=0. After release: IDLE, write ignored until start.
- Pop on empty: m_ready=1 with level=0 for 4 cycles. Required: level stays 0 and m_data=0.

Source files
------------

// File: rtl/port_sink_if.sv
// port_sink_if: bundles the two handshakes seen by a port sink.
//   Node side  : write (request), data (value), read (sink ready).
//   Host side  : m_valid / m_data (FIFO head), m_ready (host accepts).
// Modports:
//   master : the environment (node + host) driving write/data/m_ready.
//   slave  : the sink, driving read/m_valid/m_data.
interface port_sink_if #(
  parameter int WIDTH = 11
) ();
  logic             write;
  logic [WIDTH-1:0] data;
  logic             read;
  logic             m_valid;
  logic [WIDTH-1:0] m_data;
  logic             m_ready;

  modport master (output write, data, m_ready, input read, m_valid, m_data);
  modport slave  (input write, data, m_ready, output read, m_valid, m_data);
endinterface

// File: rtl/port_sink.sv
// port_sink: reader endpoint for a node write/read port. Accepted node values
// are buffered in a first-word-fall-through FIFO and drained to a host
// valid/ready stream. Accepted values are counted against a target latched on
// start; reaching a nonzero target moves the block to DONE.
// Ports:
//   clk, rst          clock, asynchronous active-low reset
//   start, target     start pulse and target count (0 = unlimited)
//   port (slave)      write/data/read node handshake, m_valid/m_data/m_ready
//   count             values accepted since the last start
//   level             FIFO occupancy
//   busy, done        state is RUN / DONE
module port_sink #(
  parameter int WIDTH = 11,
  parameter int DEPTH = 8,
  parameter int CNT_W = 8
) (
  input  logic                       clk,
  input  logic                       rst,
  input  logic                       start,
  input  logic [CNT_W-1:0]           target,
  port_sink_if.slave                 port,
  output logic [CNT_W-1:0]           count,
  output logic [$clog2(DEPTH+1)-1:0] level,
  output logic                       busy,
  output logic                       done
);

  localparam int AW = $clog2(DEPTH);
  localparam int PW = AW + 1;

  localparam logic [1:0] S_IDLE = 2'd0;
  localparam logic [1:0] S_RUN  = 2'd1;
  localparam logic [1:0] S_DONE = 2'd2;

  logic [1:0]       state_q, state_d;
  logic [CNT_W-1:0] count_q, count_d;
  logic [CNT_W-1:0] target_q, target_d;
  logic [PW-1:0]    head_q, head_d;
  logic [PW-1:0]    tail_q, tail_d;
  logic [WIDTH-1:0] mem_q [DEPTH];

  logic             full, empty, push, pop;
  logic [CNT_W-1:0] count_inc;

  // Pointers carry a wrap bit above the address bits: equal addresses with
  // differing wrap bits means full, fully equal means empty.
  assign empty = (head_q == tail_q);
  assign full  = (head_q[AW-1:0] == tail_q[AW-1:0]) && (head_q[AW] != tail_q[AW]);
  assign level = tail_q - head_q;

  // read depends only on registered state so it cannot loop back through the
  // node's write logic.
  assign port.read    = (state_q == S_RUN) && !full;
  assign port.m_valid = !empty;
  assign port.m_data  = empty ? '0 : mem_q[head_q[AW-1:0]];

  // A start on the same edge as a transfer wins: the transfer is dropped.
  assign push      = port.write && port.read && !start;
  assign pop       = !empty && port.m_ready;
  assign count_inc = count_q + 1'b1;

  always_comb begin
    state_d  = state_q;
    count_d  = count_q;
    target_d = target_q;
    head_d   = head_q;
    tail_d   = tail_q;
    if (pop)  head_d = head_q + 1'b1;
    if (push) tail_d = tail_q + 1'b1;
    if (start) begin
      state_d  = S_RUN;
      count_d  = '0;
      target_d = target;
    end else if (push) begin
      count_d = count_inc;
      if ((target_q != '0) && (count_inc == target_q)) state_d = S_DONE;
    end
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state_q  <= S_IDLE;
      count_q  <= '0;
      target_q <= '0;
      head_q   <= '0;
      tail_q   <= '0;
    end else begin
      state_q  <= state_d;
      count_q  <= count_d;
      target_q <= target_d;
      head_q   <= head_d;
      tail_q   <= tail_d;
    end
  end

  // Storage needs no reset: m_data is forced to zero while the FIFO is empty.
  always_ff @(posedge clk) begin
    if (push) mem_q[tail_q[AW-1:0]] <= port.data;
  end

  assign count = count_q;
  assign busy  = (state_q == S_RUN);
  assign done  = (state_q == S_DONE);

endmodule

// File: tb/tb_port_sink.sv
// tb_port_sink: randomized and directed stimulus for port_sink, compared each
// cycle against a queue-based reference model of the sink's behaviour.
module tb_port_sink;
  localparam int WIDTH = 11;
  localparam int DEPTH = 8;
  localparam int CNT_W = 8;
  localparam int LW    = $clog2(DEPTH+1);

  logic             clk = 1'b0;
  logic             rst = 1'b0;
  logic             start = 1'b0;
  logic [CNT_W-1:0] target = '0;
  logic [CNT_W-1:0] count;
  logic [LW-1:0]    level;
  logic             busy, done;

  port_sink_if #(.WIDTH(WIDTH)) bus ();

  port_sink #(.WIDTH(WIDTH), .DEPTH(DEPTH), .CNT_W(CNT_W)) dut (
    .clk    (clk),
    .rst    (rst),
    .start  (start),
    .target (target),
    .port   (bus),
    .count  (count),
    .level  (level),
    .busy   (busy),
    .done   (done)
  );

  always #5 clk = ~clk;

  int n_chk = 0;
  int n_err = 0;

  // Reference model
  logic [WIDTH-1:0] m_q[$];
  bit               m_run  = 1'b0;
  bit               m_done = 1'b0;
  int               m_cnt  = 0;
  int               m_tgt  = 0;

  // Node-side pending value: held until the sink accepts it.
  bit               pend   = 1'b0;
  logic [WIDTH-1:0] pend_d = '0;

  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_chk++;
    if (got !== exp) begin
      n_err++;
      $display("FAIL %s got=%0h exp=%0h at %0t", tag, got, exp, $time);
    end
  endtask

  task automatic check_outputs();
    bit mrd;
    mrd = m_run && (m_q.size() < DEPTH);
    chk("read",    32'(bus.read), 32'(mrd));
    chk("m_valid", 32'(bus.m_valid), 32'(m_q.size() != 0));
    chk("m_data",  32'(bus.m_data), (m_q.size() != 0) ? 32'(m_q[0]) : 32'd0);
    chk("count",   32'(count), 32'(m_cnt));
    chk("level",   32'(level), 32'(m_q.size()));
    chk("busy",    32'(busy), 32'(m_run));
    chk("done",    32'(done), 32'(m_done));
  endtask

  // One clock cycle: drive at negedge, check, advance the model, wait edge.
  task automatic cyc(input bit st, input logic [CNT_W-1:0] tg, input bit rdy);
    bit mrd, acc;
    @(negedge clk);
    start       = st;
    target      = tg;
    bus.write   = pend;
    bus.data    = pend ? pend_d : '0;
    bus.m_ready = rdy;
    #1;
    check_outputs();
    mrd = m_run && (m_q.size() < DEPTH);
    acc = pend && mrd && !st;
    if (rdy && m_q.size() != 0) void'(m_q.pop_front());
    if (st) begin
      m_run = 1'b1; m_done = 1'b0; m_cnt = 0; m_tgt = int'(tg);
    end else if (acc) begin
      m_q.push_back(pend_d);
      m_cnt = (m_cnt + 1) % (1 << CNT_W);
      if (m_tgt != 0 && m_cnt == m_tgt) begin
        m_run = 1'b0; m_done = 1'b1;
      end
    end
    if (acc) pend = 1'b0;
    @(posedge clk);
  endtask

  task automatic send(input logic [WIDTH-1:0] v, input bit rdy);
    int n;
    pend = 1'b1; pend_d = v; n = 0;
    while (pend && n < 50) begin
      cyc(1'b0, '0, rdy);
      n++;
    end
    chk("send_timeout", 32'(pend), 32'd0);
    pend = 1'b0;
  endtask

  task automatic drain();
    for (int i = 0; i < DEPTH + 2; i++) cyc(1'b0, '0, 1'b1);
  endtask

  task automatic async_reset();
    @(negedge clk);
    start = 1'b0; bus.write = 1'b1; bus.m_ready = 1'b0;
    #2 rst = 1'b0;
    #1;
    chk("rst_read",    32'(bus.read), 32'd0);
    chk("rst_m_valid", 32'(bus.m_valid), 32'd0);
    chk("rst_m_data",  32'(bus.m_data), 32'd0);
    chk("rst_level",   32'(level), 32'd0);
    chk("rst_count",   32'(count), 32'd0);
    chk("rst_busy",    32'(busy), 32'd0);
    chk("rst_done",    32'(done), 32'd0);
    m_q.delete(); m_run = 1'b0; m_done = 1'b0; m_cnt = 0; m_tgt = 0; pend = 1'b0;
    @(posedge clk);
    @(negedge clk);
    rst = 1'b1;
  endtask

  initial begin
    bus.write = 1'b0; bus.data = '0; bus.m_ready = 1'b0;
    repeat (2) @(posedge clk);
    #1;
    chk("init_read",    32'(bus.read), 32'd0);
    chk("init_m_valid", 32'(bus.m_valid), 32'd0);
    chk("init_level",   32'(level), 32'd0);
    chk("init_count",   32'(count), 32'd0);
    chk("init_busy",    32'(busy), 32'd0);
    chk("init_done",    32'(done), 32'd0);
    @(negedge clk);
    rst = 1'b1;

    // Target of three, back-to-back writes with an eager host.
    cyc(1'b1, 8'd3, 1'b1);
    send(11'd5, 1'b1);
    send(11'h7F9, 1'b1);
    send(11'd999, 1'b1);
    cyc(1'b0, '0, 1'b1);
    chk("t1_done", 32'(done), 32'd1);
    cyc(1'b0, '0, 1'b1);

    // Unlimited target, host stalled: fill to full, stall, single pop.
    cyc(1'b1, 8'd0, 1'b0);
    for (int i = 0; i < DEPTH; i++) send(11'(100 + i), 1'b0);
    pend = 1'b1; pend_d = 11'd108;
    cyc(1'b0, '0, 1'b0);
    cyc(1'b0, '0, 1'b0);
    chk("t2_full_level", 32'(level), 32'(DEPTH));
    cyc(1'b0, '0, 1'b1);
    cyc(1'b0, '0, 1'b0);
    chk("t2_ninth_taken", 32'(pend), 32'd0);
    send(11'd109, 1'b1);
    drain();

    // Full FIFO, continuous write and read: 32 values through.
    cyc(1'b1, 8'd0, 1'b0);
    for (int i = 0; i < DEPTH; i++) send(11'($urandom), 1'b0);
    for (int i = 0; i < 32; i++) send(11'($urandom), 1'b1);
    drain();

    // Restart while running with two values buffered; start coincides with write.
    cyc(1'b1, 8'd0, 1'b0);
    send(11'd321, 1'b0);
    send(11'h400, 1'b0);
    pend = 1'b1; pend_d = 11'd77;
    cyc(1'b1, 8'd5, 1'b0);
    cyc(1'b0, '0, 1'b0);
    drain();
    pend = 1'b0;

    // Reset mid-stream with five values buffered and write held high.
    cyc(1'b1, 8'd0, 1'b0);
    for (int i = 0; i < 5; i++) send(11'($urandom), 1'b0);
    async_reset();
    pend = 1'b1; pend_d = 11'd42;
    repeat (3) cyc(1'b0, '0, 1'b0);
    chk("t5_ignored", 32'(pend), 32'd1);

    // Pop on empty.
    pend = 1'b0;
    repeat (4) cyc(1'b0, '0, 1'b1);

    // Randomized traffic with occasional restarts and small targets.
    cyc(1'b1, 8'd0, 1'b1);
    for (int i = 0; i < 600; i++) begin
      bit st;
      if (!pend && $urandom_range(0, 3) != 0) begin
        pend = 1'b1; pend_d = 11'($urandom);
      end
      st = ($urandom_range(0, 59) == 0);
      cyc(st, 8'($urandom_range(0, 6)), $urandom_range(0, 9) < 7);
    end

    $display("Result: errors=%0d of %0d checks", n_err, n_chk);
    $finish;
  end

  initial begin
    #500000;
    $display("FAIL watchdog timeout got=running exp=finished");
    $fatal(1, "watchdog");
  end
endmodule
